mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-access (MEM stage) port. It sits between the IF/MEM stages and the memory. It accepts at most one transaction at a time and drives the memory request/grant/response handshake. It routes each response back to its owner and generates per-port stall signals for the hazard logic. Data accesses have priority, and a bounded-wait counter guarantees that fetch cannot starve.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_FETCH_WAIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- if_req  in  1  fetch request; held stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- if_stall  out  1  fetch not complete this cycle
- d_req  in  1  data request; held stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid / store acknowledged
- d_rdata  out  DATA_W  load data (don't-care for stores)
- d_stall  out  1  data access not complete this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_gnt  in  1  memory accepted the request (sampled while mem_req=1)
- mem_rvalid  in  1  memory response, one per granted request (reads and writes)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction outstanding (state ≠ IDLE)
- err_spurious  out  1  sticky: mem_rvalid seen outside WAIT; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational):
  - The winner gets its ready signal asserted in the same cycle.
  - Its addr/we/wdata and owner (IF/D) are registered at the edge, and the FSM goes to ISSUE.
  - No requests: the FSM stays in IDLE.
- Priority:
  - d_req wins over if_req, unless fetch_wait == MAX_FETCH_WAIT; then the fetch wins.
  - An IF request always has we=0.
- fetch_wait counter:
  - Increments (saturating at MAX_FETCH_WAIT) when D is granted while if_req=1.
  - Clears when IF is granted, or in any cycle with if_req=0.
  - Width: clog2(MAX_FETCH_WAIT+1).
- ISSUE:
  - mem_req=1, and mem_we/addr/wdata come from the latched registers, stable until granted.
  - mem_gnt=1 moves the FSM to WAIT.
  - mem_rvalid in ISSUE is ignored and sets err_spurious.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: the owner's rvalid is asserted for that cycle, its rdata = mem_rdata (combinational pass-through), and the FSM goes to IDLE.
  - The non-owner's rvalid stays 0.
- Ready signals are 0 in ISSUE/WAIT; requesters hold their requests.
- if_stall = (if_req & ~if_rvalid) | (owner==IF & busy & ~if_rvalid); d_stall is symmetric.
- mem_rvalid in IDLE sets err_spurious and produces no rvalid.

## Timing
- Reset values:
  - state=IDLE, fetch_wait=0, err_spurious=0.
  - Latched addr/wdata/we/owner = 0.
  - All outputs are 0 while reset=0, except that the combinational stalls still follow if_req/d_req.
- Minimum latency: ready in cycle N, mem_req in N+1; with mem_gnt=1 in N+1 and mem_rvalid in N+2, the rvalid pulse occurs in N+2.
- Back-to-back: the next acceptance is in the cycle after the rvalid (IDLE), giving a 3-cycle minimum per transaction.
- Simultaneous if_req and d_req in IDLE: D wins unless the counter is saturated; the loser waits with ready=0.
- Reset mid-transaction: the FSM immediately returns to IDLE and the pending transaction is abandoned. A late mem_rvalid after reset release arrives in IDLE and is dropped, setting err_spurious.

## Test plan
- Single fetch, if_addr=0x10, gnt immediate, mem_rdata=0x00500093 one cycle later -> if_ready in cycle 0, mem_req in cycle 1 with mem_addr=0x10 and mem_we=0, if_rvalid in cycle 2 with if_rdata=0x00500093; d_rvalid never asserted.
- Store d_addr=0x40, d_wdata=0xDEADBEEF, mem_gnt delayed 3 cycles -> mem_req and mem_addr/wdata/we=1 held stable for 4 cycles, d_stall=1 until d_rvalid; d_rdata ignored.
- if_req and d_req both continuously high, MAX_FETCH_WAIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; if_stall high throughout except on its rvalid cycles.
- Simultaneous requests in IDLE with counter 0 -> d_ready=1 and if_ready=0; if_req held and granted on the next IDLE cycle.
- reset driven low during WAIT -> busy=0 and mem_req=0 immediately; after release, a late mem_rvalid produces no rvalid and sets err_spurious=1, which stays 1 until the next reset.
- mem_rvalid pulsed in ISSUE before mem_gnt -> ignored, err_spurious=1, and the transaction still completes normally on the real response.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch (IF)
//   port and the data-access (D) port. One transaction is in flight at a time:
//   IDLE arbitrates and latches the winner, ISSUE holds mem_req until mem_gnt,
//   WAIT forwards the single mem_rvalid response to the owning port.
//   Data accesses have priority; a bounded-wait counter lets a pending fetch win
//   after MAX_FETCH_WAIT consecutive data grants.
//
// Ports
//   clk, reset (async, active-low)
//   IF  : if_req/if_addr in; if_ready, if_rvalid, if_rdata, if_stall out
//   D   : d_req/d_we/d_addr/d_wdata in; d_ready, d_rvalid, d_rdata, d_stall out
//   MEM : mem_req/mem_we/mem_addr/mem_wdata out; mem_gnt/mem_rvalid/mem_rdata in
//   busy         : a transaction is outstanding
//   err_spurious : sticky, mem_rvalid seen outside WAIT
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_FETCH_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_spurious
);

  localparam int unsigned     FW_W   = $clog2(MAX_FETCH_WAIT + 1);
  localparam logic [FW_W-1:0] FW_MAX = FW_W'(MAX_FETCH_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = data port owns, 0 = fetch
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [FW_W-1:0]   fetch_wait_q, fetch_wait_d;
  logic              err_q, err_d;

  logic              if_ready_c, d_ready_c;
  logic              if_rvalid_c, d_rvalid_c;
  logic              fetch_wins;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_d_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fetch_wait_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_d_q    <= owner_d_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fetch_wait_q <= fetch_wait_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d_d    = owner_d_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fetch_wait_d = fetch_wait_q;
    err_d        = err_q;
    if_ready_c   = 1'b0;
    d_ready_c    = 1'b0;
    if_rvalid_c  = 1'b0;
    d_rvalid_c   = 1'b0;
    mem_req      = 1'b0;
    fetch_wins   = if_req && (fetch_wait_q == FW_MAX);

    unique case (state_q)
      ST_IDLE: begin
        if (d_req && !fetch_wins) begin
          d_ready_c = 1'b1;
          owner_d_d = 1'b1;
          we_d      = d_we;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          state_d   = ST_ISSUE;
          if (if_req) begin
            fetch_wait_d = (fetch_wait_q == FW_MAX) ? FW_MAX : fetch_wait_q + 1'b1;
          end
        end else if (if_req) begin
          if_ready_c   = 1'b1;
          owner_d_d    = 1'b0;
          we_d         = 1'b0;
          addr_d       = if_addr;
          wdata_d      = '0;
          state_d      = ST_ISSUE;
          fetch_wait_d = '0;
        end
        if (mem_rvalid) err_d = 1'b1;
      end
      ST_ISSUE: begin
        mem_req = 1'b1;
        if (mem_rvalid) err_d = 1'b1;
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (owner_d_q) d_rvalid_c  = 1'b1;
          else           if_rvalid_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A cycle with no fetch request restarts the wait count.
    if (!if_req) fetch_wait_d = '0;
  end

  // State is held at IDLE asynchronously during reset, but the IDLE ready
  // terms still see the requests, so they are masked by reset explicitly.
  assign if_ready  = if_ready_c & reset;
  assign d_ready   = d_ready_c & reset;
  assign if_rvalid = if_rvalid_c;
  assign d_rvalid  = d_rvalid_c;
  assign if_rdata  = if_rvalid_c ? mem_rdata : '0;
  assign d_rdata   = d_rvalid_c ? mem_rdata : '0;

  assign busy         = (state_q != ST_IDLE);
  assign err_spurious = err_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

  assign if_stall = (if_req & ~if_rvalid_c) | (~owner_d_q & busy & ~if_rvalid_c);
  assign d_stall  = (d_req & ~d_rvalid_c) | (owner_d_q & busy & ~d_rvalid_c);

endmodule
